hazard_stall_unit: RTL and testbench
====================================

Name: hazard_stall_unit

Overview:
- Pipeline hazard/stall controller for the 5-stage core; sits in ID beside the forwarding unit and drives the stage-register write enables and flushes.
- Covers load-use hazards that forwarding cannot resolve, taken-branch flushes from EX, and multi-cycle data-memory waits from MEM.
- Sequential part tracks the memory wait, timeout and a pending branch so that no event is lost while the pipeline is frozen.

Parameters:
- TIMEOUT, 64, max consecutive MEM wait cycles before the sticky error flag sets.
- CW, 7, width of the wait counter; TIMEOUT must be less than 2^CW.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous reset, active low.
- id_rs1  in  5  rs1 of the instruction in ID.
- id_rs2  in  5  rs2 of the instruction in ID.
- ex_rd  in  5  rd of the instruction in EX.
- ex_memread  in  1  the instruction in EX is a load.
- ex_branch_taken  in  1  branch or jump in EX resolved taken.
- mem_req  in  1  MEM stage has a data-memory access in flight.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_write  out  1  PC update enable.
- ifid_write  out  1  IF/ID register write enable.
- idex_write, exmem_write, memwb_write  out  1 each  stage-register write enables.
- ifid_flush, idex_flush  out  1 each  load a NOP into that register.
- mem_timeout  out  1  sticky wait-timeout error flag.

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is synchronous, active low.
- Output timing: outputs are combinational from current state and inputs, so there is zero latency from hazard to control.
- While rst_n=0: all write enables 0, ifid_flush=1, idex_flush=1, mem_timeout=0. The next edge loads state RUN, wait_cnt=0, br_pend=0, mem_timeout=0.
- Terms:
  - freeze = mem_req & ~mem_ready.
  - lu = ex_memread & (ex_rd!=0) & (ex_rd==id_rs1 | ex_rd==id_rs2).
  - br = ex_branch_taken | br_pend.
- Priority is freeze > br > lu.
- freeze: all five write enables 0, both flushes 0.
- br (no freeze): all write enables 1, ifid_flush=1, idex_flush=1. Branch overrides lu because the ID instruction is squashed anyway.
- lu (no freeze, no br): pc_write=0, ifid_write=0, idex_flush=1, idex_write=1, exmem_write=1, memwb_write=1. This inserts exactly one bubble; detection clears by itself once the load reaches MEM.
- Default: all write enables 1, both flushes 0.
- FSM states are RUN and WAIT.
  - RUN to WAIT when freeze at the edge. wait_cnt=1; br_pend=ex_branch_taken.
  - WAIT stays WAIT while freeze. wait_cnt increments and saturates at TIMEOUT. br_pend |= ex_branch_taken.
  - WAIT to RUN on the first edge with mem_ready=1 (freeze already low that cycle, so the unfreeze cycle applies br/lu normally). wait_cnt=0.
  - br_pend clears on the first non-freeze edge, after its flush has been applied for exactly one cycle.
- mem_timeout sets when wait_cnt==TIMEOUT and freeze is still high. It stays high until reset; the pipeline remains frozen and the error does not force an exit.
- mem_ready=1 with mem_req=0 is ignored.
- ex_rd=0 never triggers lu (x0).
- Reset asserted mid-WAIT: reset wins at the next edge; br_pend is discarded.

Optional Feature:
- Macro HAZARD_STATS_EN enables three 16-bit counters with ports:
  - stat_lu_stalls  out 16: +1 per cycle with lu applied.
  - stat_wait_cycles  out 16: +1 per freeze cycle.
  - stat_flushes  out 16: +1 per cycle with br applied.
- Counters saturate at 0xFFFF and reset to 0.
- Without the macro the ports still exist and are tied to 0; no counter logic is built.

Test Plan:
- Load-use: ex_memread=1, ex_rd=5, id_rs1=5 for one cycle → pc_write=0, ifid_write=0, idex_flush=1; next cycle with ex_memread=0 → all defaults.
- x0 guard: ex_memread=1, ex_rd=0, id_rs2=0 → no stall; all write enables 1, flushes 0.
- Branch vs load-use: ex_branch_taken=1 together with an lu condition (rd=3, rs2=3) → ifid_flush=1, idex_flush=1, pc_write=1, no lu stall.
- Memory wait with pending branch:
  - mem_req=1, mem_ready=0 for 4 cycles, ex_branch_taken=1 in wait cycle 2 → all write enables 0 for 4 cycles.
  - Cycle 5, mem_ready=1 → writes 1, ifid_flush=idex_flush=1 for exactly 1 cycle (br_pend), then default.
- Timeout: TIMEOUT=8, hold mem_req=1, mem_ready=0 for 12 cycles → mem_timeout rises when wait_cnt==8 with freeze still high and stays 1 after mem_ready=1; clears only after rst_n=0 for one edge.
- Reset mid-wait: rst_n=0 during cycle 3 of a wait with br_pend=1 → during reset writes=0, flushes=1. After release with no hazards → defaults, no stale flush; with HAZARD_STATS_EN all counters read 0.

Source files
------------

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit
// Pipeline hazard/stall controller for the 5-stage core. Sits in ID beside
// the forwarding unit and produces the stage-register write enables and
// flushes for load-use stalls, taken-branch flushes and data-memory waits.
//
// Parameters:
//   TIMEOUT  max consecutive MEM wait cycles before mem_timeout sets
//   CW       wait counter width, TIMEOUT < 2**CW
//
// Ports:
//   clk, rst_n                   clock, synchronous active-low reset
//   id_rs1, id_rs2               source registers of the ID instruction
//   ex_rd, ex_memread            destination / load flag of the EX instruction
//   ex_branch_taken              branch or jump in EX resolved taken
//   mem_req, mem_ready           MEM access in flight / completes this cycle
//   pc_write .. memwb_write      PC and stage-register write enables
//   ifid_flush, idex_flush       load a NOP into IF/ID, ID/EX
//   mem_timeout                  sticky wait-timeout error flag
//   stat_lu_stalls               load-use stall cycles    (HAZARD_STATS_EN)
//   stat_wait_cycles             memory freeze cycles     (HAZARD_STATS_EN)
//   stat_flushes                 branch flush cycles      (HAZARD_STATS_EN)
//
// Build option: define HAZARD_STATS_EN to build the saturating 16-bit event
// counters; otherwise the stat_* ports are tied to zero.
//
// Control outputs are combinational from current state and inputs so that a
// hazard is acted on in the same cycle it is detected.

module hazard_stall_unit #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CW      = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_memread,
    input  logic        ex_branch_taken,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        idex_write,
    output logic        exmem_write,
    output logic        memwb_write,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        mem_timeout,
    output logic [15:0] stat_lu_stalls,
    output logic [15:0] stat_wait_cycles,
    output logic [15:0] stat_flushes
);

    localparam int unsigned STAT_W = 16;
    localparam logic [CW-1:0] TIMEOUT_CNT = CW'(TIMEOUT);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic          br_pend_q, br_pend_d;
    logic          timeout_q, timeout_d;

    logic          freeze_c;
    logic          lu_c;
    logic          br_c;

    // Hazard terms
    assign freeze_c = mem_req & ~mem_ready;
    // x0 is never a real producer, so rd==0 must not stall
    assign lu_c     = ex_memread & (ex_rd != 5'd0) &
                      ((ex_rd == id_rs1) | (ex_rd == id_rs2));
    // A branch seen while frozen is replayed from br_pend on the unfreeze cycle
    assign br_c     = ex_branch_taken | br_pend_q;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
            br_pend_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            br_pend_q  <= br_pend_d;
            timeout_q  <= timeout_d;
        end
    end

    // Next-state logic: wait tracking, pending branch, sticky timeout
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        br_pend_d  = br_pend_q;
        timeout_d  = timeout_q;

        if (state_q == ST_RUN) begin
            if (freeze_c) begin
                state_d    = ST_WAIT;
                wait_cnt_d = CW'(1);
                br_pend_d  = ex_branch_taken;
            end else begin
                wait_cnt_d = '0;
                br_pend_d  = 1'b0;
            end
        end else begin
            if (freeze_c) begin
                // Counter saturates; the error is flagged but never forces an exit
                if (wait_cnt_q == TIMEOUT_CNT) begin
                    timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + CW'(1);
                end
                br_pend_d = br_pend_q | ex_branch_taken;
            end else begin
                // Unfreeze cycle already applied br_pend as a flush; drop it now
                state_d    = ST_RUN;
                wait_cnt_d = '0;
                br_pend_d  = 1'b0;
            end
        end
    end

    // Output logic: priority freeze > branch > load-use > run
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_write  = 1'b1;
        exmem_write = 1'b1;
        memwb_write = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        mem_timeout = rst_n & timeout_q;

        if (!rst_n) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_write = 1'b0;
            memwb_write = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
        end else if (freeze_c) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_write = 1'b0;
            memwb_write = 1'b0;
        end else if (br_c) begin
            // ID instruction is squashed, so a coincident load-use is moot
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
        end else if (lu_c) begin
            // Hold PC and IF/ID, push one bubble into EX
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_flush  = 1'b1;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [STAT_W-1:0] lu_cnt_q, lu_cnt_d;
    logic [STAT_W-1:0] wait_stat_q, wait_stat_d;
    logic [STAT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic              lu_apply_c;
    logic              br_apply_c;

    assign br_apply_c = ~freeze_c & br_c;
    assign lu_apply_c = ~freeze_c & ~br_c & lu_c;

    // Saturating event counters
    always_comb begin
        lu_cnt_d    = lu_cnt_q;
        wait_stat_d = wait_stat_q;
        flush_cnt_d = flush_cnt_q;
        if (lu_apply_c && (lu_cnt_q != '1)) begin
            lu_cnt_d = lu_cnt_q + STAT_W'(1);
        end
        if (freeze_c && (wait_stat_q != '1)) begin
            wait_stat_d = wait_stat_q + STAT_W'(1);
        end
        if (br_apply_c && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + STAT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lu_cnt_q    <= '0;
            wait_stat_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            lu_cnt_q    <= lu_cnt_d;
            wait_stat_q <= wait_stat_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stat_lu_stalls   = lu_cnt_q;
    assign stat_wait_cycles = wait_stat_q;
    assign stat_flushes     = flush_cnt_q;
`else
    assign stat_lu_stalls   = STAT_W'(0);
    assign stat_wait_cycles = STAT_W'(0);
    assign stat_flushes     = STAT_W'(0);
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Testbench for hazard_stall_unit: directed vector table, hand-written
// timeout / reset-in-wait sequences, then random stimulus against a
// cycle-level reference model built from the hazard rules.

module tb_hazard_stall_unit;

    localparam int unsigned TO = 8;

    // Control word packing: {pc, ifid, idex, exmem, memwb, ifid_fl, idex_fl, timeout}
    localparam logic [7:0] C_RST = 8'h06;
    localparam logic [7:0] C_DEF = 8'hF8;
    localparam logic [7:0] C_FRZ = 8'h00;
    localparam logic [7:0] C_BR  = 8'hFE;
    localparam logic [7:0] C_LU  = 8'h3A;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        ex_memread, ex_branch_taken, mem_req, mem_ready;
    logic        pc_write, ifid_write, idex_write, exmem_write, memwb_write;
    logic        ifid_flush, idex_flush, mem_timeout;
    logic [15:0] stat_lu_stalls, stat_wait_cycles, stat_flushes;

    always #5 clk = ~clk;

    hazard_stall_unit #(.TIMEOUT(TO), .CW(7)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .ex_rd           (ex_rd),
        .ex_memread      (ex_memread),
        .ex_branch_taken (ex_branch_taken),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .idex_write      (idex_write),
        .exmem_write     (exmem_write),
        .memwb_write     (memwb_write),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .mem_timeout     (mem_timeout),
        .stat_lu_stalls  (stat_lu_stalls),
        .stat_wait_cycles(stat_wait_cycles),
        .stat_flushes    (stat_flushes)
    );

    typedef struct {
        logic       rst_n;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       mr;
        logic       bt;
        logic       rq;
        logic       ry;
        logic [7:0] exp;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Reference model state: consecutive frozen cycles, deferred branch, error, stats
    int m_consec = 0;
    bit m_pend   = 1'b0;
    bit m_to     = 1'b0;
    int m_lu     = 0;
    int m_wait   = 0;
    int m_fl     = 0;

    function automatic vec_t mk(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic mr, input logic bt,
                                input logic rq, input logic ry, input logic [7:0] exp);
        vec_t v;
        v.rst_n = r; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
        v.mr = mr; v.bt = bt; v.rq = rq; v.ry = ry; v.exp = exp;
        return v;
    endfunction

    function automatic logic [7:0] model_out(input vec_t v);
        bit fz, lu, br;
        if (!v.rst_n) return C_RST;
        fz = v.rq && !v.ry;
        lu = v.mr && (v.rd != 0) && (v.rd == v.rs1 || v.rd == v.rs2);
        br = v.bt || m_pend;
        if (fz) return {7'b0000000, m_to};
        if (br) return {7'b1111111, m_to};
        if (lu) return {7'b0011101, m_to};
        return {7'b1111100, m_to};
    endfunction

    task automatic model_edge(input vec_t v);
        bit fz, lu, br;
        fz = v.rq && !v.ry;
        lu = v.mr && (v.rd != 0) && (v.rd == v.rs1 || v.rd == v.rs2);
        br = v.bt || m_pend;
        if (!v.rst_n) begin
            m_consec = 0; m_pend = 0; m_to = 0;
            m_lu = 0; m_wait = 0; m_fl = 0;
        end else if (fz) begin
            if (m_consec >= int'(TO)) m_to = 1;
            m_consec++;
            m_pend = m_pend | v.bt;
            if (m_wait < 65535) m_wait++;
        end else begin
            m_consec = 0;
            m_pend   = 0;
            if (br) begin
                if (m_fl < 65535) m_fl++;
            end else if (lu) begin
                if (m_lu < 65535) m_lu++;
            end
        end
    endtask

    // Drive at negedge, compare 1 ns later, advance model across the next posedge
    task automatic run_vec(input vec_t v, input string name);
        logic [7:0]  got;
        logic [47:0] st_got, st_exp;
        rst_n = v.rst_n; id_rs1 = v.rs1; id_rs2 = v.rs2; ex_rd = v.rd;
        ex_memread = v.mr; ex_branch_taken = v.bt; mem_req = v.rq; mem_ready = v.ry;
        #1;
        got = {pc_write, ifid_write, idex_write, exmem_write, memwb_write,
               ifid_flush, idex_flush, mem_timeout};
        checks++;
        if (got !== v.exp) begin
            errors++;
            $display("FAIL %s ctrl got %b exp %b", name, got, v.exp);
        end
        st_got = {stat_lu_stalls, stat_wait_cycles, stat_flushes};
`ifdef HAZARD_STATS_EN
        st_exp = {16'(m_lu), 16'(m_wait), 16'(m_fl)};
`else
        st_exp = 48'h0;
`endif
        checks++;
        if (st_got !== st_exp) begin
            errors++;
            $display("FAIL %s stats got %h exp %h", name, st_got, st_exp);
        end
        model_edge(v);
        @(posedge clk);
        @(negedge clk);
    endtask

    vec_t tbl[16];

    initial begin
        vec_t v;
        int   burst = 0;

        rst_n = 1'b0; id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        ex_memread = 1'b0; ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;

        //            rst rs1 rs2 rd  mr bt rq ry  expected
        tbl[0]  = mk(0, 0,  0,  0,  0, 0, 0, 0, C_RST);  // reset
        tbl[1]  = mk(0, 5,  5,  5,  1, 1, 1, 0, C_RST);  // reset dominates hazards
        tbl[2]  = mk(1, 0,  0,  0,  0, 0, 0, 0, C_DEF);  // idle
        tbl[3]  = mk(1, 5,  1,  5,  1, 0, 0, 0, C_LU);   // load-use via rs1
        tbl[4]  = mk(1, 5,  1,  5,  0, 0, 0, 0, C_DEF);  // load moved on
        tbl[5]  = mk(1, 0,  0,  0,  1, 0, 0, 0, C_DEF);  // x0 never stalls
        tbl[6]  = mk(1, 1,  3,  3,  1, 1, 0, 0, C_BR);   // branch beats load-use
        tbl[7]  = mk(1, 2,  7,  7,  1, 0, 0, 0, C_LU);   // load-use via rs2
        tbl[8]  = mk(1, 5,  6,  4,  1, 0, 0, 0, C_DEF);  // no register match
        tbl[9]  = mk(1, 0,  0,  0,  0, 0, 0, 1, C_DEF);  // ready without req ignored
        tbl[10] = mk(1, 5,  1,  5,  1, 0, 1, 0, C_FRZ);  // wait 1 (freeze beats lu)
        tbl[11] = mk(1, 0,  0,  0,  0, 1, 1, 0, C_FRZ);  // wait 2, branch arrives
        tbl[12] = mk(1, 0,  0,  0,  0, 0, 1, 0, C_FRZ);  // wait 3
        tbl[13] = mk(1, 0,  0,  0,  0, 0, 1, 0, C_FRZ);  // wait 4
        tbl[14] = mk(1, 0,  0,  0,  0, 0, 1, 1, C_BR);   // unfreeze: pending flush
        tbl[15] = mk(1, 0,  0,  0,  0, 0, 0, 0, C_DEF);  // pending flush gone

        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            run_vec(tbl[i], $sformatf("vec%0d", i));
        end

        // Timeout: 12 frozen cycles, flag visible once TO waits have elapsed
        for (int k = 1; k <= 12; k++) begin
            run_vec(mk(1, 0, 0, 0, 0, 0, 1, 0, (k >= int'(TO) + 2) ? 8'h01 : C_FRZ),
                    $sformatf("to_wait%0d", k));
        end
        run_vec(mk(1, 0, 0, 0, 0, 0, 1, 1, C_DEF | 8'h01), "to_ready");
        run_vec(mk(1, 0, 0, 0, 0, 0, 0, 0, C_DEF | 8'h01), "to_sticky");
        run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, C_RST), "to_reset");
        run_vec(mk(1, 0, 0, 0, 0, 0, 0, 0, C_DEF), "to_cleared");

        // Reset in the middle of a wait with a pending branch
        run_vec(mk(1, 0, 0, 0, 0, 0, 1, 0, C_FRZ), "rw_wait1");
        run_vec(mk(1, 0, 0, 0, 0, 1, 1, 0, C_FRZ), "rw_wait2_br");
        run_vec(mk(0, 0, 0, 0, 0, 1, 1, 0, C_RST), "rw_reset");
        run_vec(mk(1, 0, 0, 0, 0, 0, 0, 0, C_DEF), "rw_release");
        run_vec(mk(1, 0, 0, 0, 0, 0, 0, 0, C_DEF), "rw_idle");

        // Random traffic with occasional long memory waits and resets
        for (int n = 0; n < 3000; n++) begin
            v.rst_n = ($urandom_range(0, 99) != 0);
            v.rs1   = 5'($urandom_range(0, 3));
            v.rs2   = 5'($urandom_range(0, 3));
            v.rd    = 5'($urandom_range(0, 3));
            v.mr    = 1'($urandom_range(0, 1));
            v.bt    = ($urandom_range(0, 5) == 0);
            if (burst == 0 && $urandom_range(0, 19) == 0) begin
                burst = int'($urandom_range(3, 14));
            end
            if (burst > 0) begin
                v.rq = 1'b1; v.ry = 1'b0; burst--;
            end else begin
                v.rq = 1'($urandom_range(0, 1));
                v.ry = 1'($urandom_range(0, 1));
            end
            v.exp = model_out(v);
            run_vec(v, $sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
